// File: rtl/ibex_rf_wr_arbiter_if.sv
// Write-side bundle of the RF write arbiter: the lsu and ex writeback requests
// and the single register file write port they share.
interface ibex_rf_wr_arbiter_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 lsu_we_i;
  logic [4:0]           lsu_waddr_i;
  logic [DataWidth-1:0] lsu_wdata_i;
  logic                 ex_valid_i;
  logic [4:0]           ex_waddr_i;
  logic [DataWidth-1:0] ex_wdata_i;
  logic                 ex_ready_o;
  logic                 rf_we_o;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;

  modport master (
    output lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    output ex_valid_i, ex_waddr_i, ex_wdata_i,
    input  ex_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o
  );

  modport slave (
    input  lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    input  ex_valid_i, ex_waddr_i, ex_wdata_i,
    output ex_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o
  );
endinterface

// File: rtl/ibex_rf_wr_arbiter.sv
// Single-port RF write arbiter: lsu writes win, a colliding ex write is parked
// in a one-entry skid buffer and drained on the next lsu-free cycle.
module ibex_rf_wr_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ibex_rf_wr_arbiter_if.slave  wr,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 fwd_a_o,
  output logic                 fwd_b_o,
  output logic [DataWidth-1:0] fwd_wdata_o,
  output logic                 idle_o,
  output logic [15:0]          conflict_cnt_o
);

  localparam logic [0:0] StEmpty  = 1'b0;
  localparam logic [0:0] StFull   = 1'b1;
  // RV32E only has x0..x15, so bit 4 never participates.
  localparam logic [4:0] AddrMask = RV32E ? 5'h0F : 5'h1F;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [0:0]           state_q;
  logic [4:0]           buf_addr_q;
  logic [DataWidth-1:0] buf_data_q;
  logic [15:0]          cnt_q;

  logic                 buf_valid;
  logic                 ex_acc;
  logic                 capture;
  logic                 sel_vld;
  logic [4:0]           sel_addr;
  logic [DataWidth-1:0] sel_data;
  logic [4:0]           sel_addr_m;
  logic [4:0]           buf_addr_m;
  logic [4:0]           raddr_a_m;
  logic [4:0]           raddr_b_m;

  assign buf_valid     = (state_q == StFull);
  assign wr.ex_ready_o = !buf_valid;
  assign ex_acc        = wr.ex_valid_i && !buf_valid;
  assign capture       = wr.lsu_we_i && ex_acc;

  always_comb begin
    sel_vld  = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (wr.lsu_we_i) begin
      sel_vld  = 1'b1;
      sel_addr = wr.lsu_waddr_i;
      sel_data = wr.lsu_wdata_i;
    end else if (buf_valid) begin
      sel_vld  = 1'b1;
      sel_addr = buf_addr_q;
      sel_data = buf_data_q;
    end else if (ex_acc) begin
      sel_vld  = 1'b1;
      sel_addr = wr.ex_waddr_i;
      sel_data = wr.ex_wdata_i;
    end
  end

  // x0 writes still arbitrate and drain normally; only the enable is masked.
  assign sel_addr_m    = sel_addr & AddrMask;
  assign wr.rf_waddr_o = sel_addr_m;
  assign wr.rf_wdata_o = sel_data;
  assign wr.rf_we_o    = sel_vld && (sel_addr_m != 5'd0);

  assign buf_addr_m  = buf_addr_q & AddrMask;
  assign raddr_a_m   = raddr_a_i & AddrMask;
  assign raddr_b_m   = raddr_b_i & AddrMask;
  assign fwd_a_o     = buf_valid && (buf_addr_m == raddr_a_m) && (raddr_a_m != 5'd0);
  assign fwd_b_o     = buf_valid && (buf_addr_m == raddr_b_m) && (raddr_b_m != 5'd0);
  assign fwd_wdata_o = buf_valid ? buf_data_q : '0;

  assign idle_o         = !buf_valid;
  assign conflict_cnt_o = cnt_q;

  // Skid buffer state and collision counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StEmpty;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (capture) begin
            state_q    <= StFull;
            buf_addr_q <= wr.ex_waddr_i;
            buf_data_q <= wr.ex_wdata_i;
          end
        end
        default: begin
          if (!wr.lsu_we_i) begin
            state_q <= StEmpty;
          end
        end
      endcase
      if (wr.lsu_we_i && wr.ex_valid_i) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end
  end

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// Scoreboard bench for ibex_rf_wr_arbiter: a queue-based reference model
// predicts every cycle's outputs, a negedge monitor compares them.
module tb_ibex_rf_wr_arbiter;

  logic        clk;
  logic        rst_ni;
  logic [4:0]  raddr_a, raddr_b;
  logic        fwd_a, fwd_b;
  logic [31:0] fwd_wdata;
  logic        idle;
  logic [15:0] conflict_cnt;

  ibex_rf_wr_arbiter_if #(.DataWidth(32)) wr_if ();

  ibex_rf_wr_arbiter #(.DataWidth(32), .RV32E(1'b0)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .wr             (wr_if),
    .raddr_a_i      (raddr_a),
    .raddr_b_i      (raddr_b),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b),
    .fwd_wdata_o    (fwd_wdata),
    .idle_o         (idle),
    .conflict_cnt_o (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rdy;
    logic        idl;
    logic [15:0] cnt;
    logic        fa;
    logic        fb;
    logic [31:0] fd;
  } exp_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  exp_t        sb[$];
  ent_t        pend[$];
  int unsigned m_cnt;
  int          n_checks;
  int          n_errs;

  // Reference: pending ex writes live in a queue; the RF port takes lsu first,
  // then the oldest pending ex write, then a fresh ex write if one is accepted.
  task automatic cyc(input bit lw, input logic [4:0] la, input logic [31:0] ld,
                     input bit ev, input logic [4:0] ea, input logic [31:0] ed,
                     input logic [4:0] ra, input logic [4:0] rb,
                     input string tag, input bit rst_mid = 1'b0);
    exp_t        e;
    bit          have;
    logic [4:0]  a;
    logic [31:0] d;
    bit          accepted;
    ent_t        n;
    @(posedge clk);
    #1;
    wr_if.lsu_we_i    = lw;
    wr_if.lsu_waddr_i = la;
    wr_if.lsu_wdata_i = ld;
    wr_if.ex_valid_i  = ev;
    wr_if.ex_waddr_i  = ea;
    wr_if.ex_wdata_i  = ed;
    raddr_a           = ra;
    raddr_b           = rb;
    if (rst_mid) begin
      #2;
      rst_ni = 1'b0;
      pend.delete();
      m_cnt = 0;
    end
    e.tag = tag;
    e.rdy = (pend.size() == 0);
    e.idl = (pend.size() == 0);
    e.cnt = m_cnt[15:0];
    have = 1'b0;
    a    = 5'd0;
    d    = 32'd0;
    if (lw) begin
      have = 1'b1; a = la; d = ld;
    end else if (pend.size() != 0) begin
      have = 1'b1; a = pend[0].a; d = pend[0].d;
    end else if (ev) begin
      have = 1'b1; a = ea; d = ed;
    end
    e.we = have && (a != 5'd0);
    e.wa = a;
    e.wd = d;
    e.fa = (pend.size() != 0) && (pend[0].a == ra) && (ra != 5'd0);
    e.fb = (pend.size() != 0) && (pend[0].a == rb) && (rb != 5'd0);
    e.fd = (pend.size() != 0) ? pend[0].d : 32'd0;
    sb.push_back(e);
    if (rst_mid) begin
      #5;
      rst_ni = 1'b1;
    end
    accepted = ev && (pend.size() == 0);
    if (lw && accepted) begin
      n.a = ea;
      n.d = ed;
      pend.push_back(n);
    end else if (!lw && pend.size() != 0) begin
      void'(pend.pop_front());
    end
    if (lw && ev && m_cnt < 65535) m_cnt = m_cnt + 1;
  endtask

  task automatic idle_cyc(input string tag);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, tag);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if (wr_if.rf_we_o !== e.we || wr_if.rf_waddr_o !== e.wa || wr_if.rf_wdata_o !== e.wd) begin
        n_errs++;
        $display("FAIL %s rf_write: got we=%b addr=%0d data=%h, want we=%b addr=%0d data=%h",
                 e.tag, wr_if.rf_we_o, wr_if.rf_waddr_o, wr_if.rf_wdata_o, e.we, e.wa, e.wd);
      end
      n_checks++;
      if (wr_if.ex_ready_o !== e.rdy || idle !== e.idl || conflict_cnt !== e.cnt) begin
        n_errs++;
        $display("FAIL %s status: got ready=%b idle=%b cnt=%h, want ready=%b idle=%b cnt=%h",
                 e.tag, wr_if.ex_ready_o, idle, conflict_cnt, e.rdy, e.idl, e.cnt);
      end
      n_checks++;
      if (fwd_a !== e.fa || fwd_b !== e.fb || fwd_wdata !== e.fd) begin
        n_errs++;
        $display("FAIL %s forward: got a=%b b=%b data=%h, want a=%b b=%b data=%h",
                 e.tag, fwd_a, fwd_b, fwd_wdata, e.fa, e.fb, e.fd);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached with %0d entries queued", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ra;
    n_checks = 0;
    n_errs   = 0;
    m_cnt    = 0;
    rst_ni   = 1'b0;
    wr_if.lsu_we_i    = 1'b0;
    wr_if.lsu_waddr_i = 5'd0;
    wr_if.lsu_wdata_i = 32'd0;
    wr_if.ex_valid_i  = 1'b0;
    wr_if.ex_waddr_i  = 5'd0;
    wr_if.ex_wdata_i  = 32'd0;
    raddr_a = 5'd0;
    raddr_b = 5'd0;

    // Reset held: outputs track the current inputs only
    idle_cyc("rst_idle");
    cyc(1'b1, 5'd4, 32'h0000_0044, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0, "rst_lsu");
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h0000_0066, 5'd6, 5'd6, "rst_ex");
    #6 rst_ni = 1'b1;

    // Direct ex write
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5A5_A5A5, 5'd5, 5'd0, "ex_direct");

    // Collision then drain
    cyc(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 5'd7, 5'd3, "coll_c0");
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd3, "coll_c1");
    idle_cyc("coll_c2");

    // Buffer holds addr 9 under sustained lsu traffic, ex waits
    cyc(1'b1, 5'd1, 32'h1111, 1'b1, 5'd9, 32'h9999_0009, 5'd9, 5'd2, "hold_fill");
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 5'(i + 10), 32'($urandom), 1'b1, 5'd12, 32'h0C0C_0C0C, 5'd9, 5'd9, "hold_lsu");
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h0C0C_0C0C, 5'd9, 5'd12, "hold_drain");
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h0C0C_0C0C, 5'd9, 5'd12, "hold_next");

    // Same destination for lsu and buffered ex: buffer lands last
    cyc(1'b1, 5'd8, 32'hAAAA, 1'b1, 5'd8, 32'hBBBB, 5'd8, 5'd0, "same_c0");
    cyc(1'b1, 5'd8, 32'hCCCC, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0, "same_c1");
    idle_cyc("same_c2");

    // x0 writes
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, "ex_x0");
    cyc(1'b1, 5'd2, 32'h2, 1'b1, 5'd0, 32'hFACE, 5'd0, 5'd0, "x0_buf");
    idle_cyc("x0_drain");
    cyc(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "lsu_x0");

    // Asynchronous reset mid-cycle discards the buffered write
    cyc(1'b1, 5'd14, 32'hE, 1'b1, 5'd15, 32'hF0F0_F0F0, 5'd15, 5'd0, "arst_fill");
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd15, 5'd0, "arst_pulse", 1'b1);
    idle_cyc("arst_after");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      ra = (pend.size() != 0 && $urandom_range(0, 1) == 1) ? pend[0].a : 5'($urandom_range(0, 31));
      cyc($urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), 32'($urandom),
          $urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), 32'($urandom),
          ra, 5'($urandom_range(0, 31)), "rand");
    end
    idle_cyc("rand_end");

    // Counter saturation under continuous collisions
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "sat_rst", 1'b1);
    for (int i = 0; i < 65540; i++)
      cyc(1'b1, 5'($urandom_range(1, 31)), 32'($urandom), 1'b1, 5'($urandom_range(1, 31)),
          32'($urandom), 5'd0, 5'd0, "sat");
    idle_cyc("sat_drain");
    idle_cyc("sat_end");

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errs++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
